// File: rtl/uart_tx_fifo_if.sv
// Handshake and status bundle between the reply source, the byte FIFO and uart_tx.
// The master side feeds bytes and transmitter busy; the slave side is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [7:0]          tx_data_o;
    logic                tx_write_o;
    logic                tx_busy_i;
    logic [DEPTH_LOG2:0] count_o;
    logic                empty_o;
    logic                full_o;
    logic                overflow_o;
    logic                clear_overflow_i;

    modport master (
        output in_data_i,
        output in_valid_i,
        output tx_busy_i,
        output clear_overflow_i,
        input  in_ready_o,
        input  tx_data_o,
        input  tx_write_o,
        input  count_o,
        input  empty_o,
        input  full_o,
        input  overflow_o
    );

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        input  tx_busy_i,
        input  clear_overflow_i,
        output in_ready_o,
        output tx_data_o,
        output tx_write_o,
        output count_o,
        output empty_o,
        output full_o,
        output overflow_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that absorbs bursts of reply bytes and paces them into uart_tx,
// one write strobe per byte, using the transmitter's busy flag.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_STEP  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_STEP    = DEPTH_LOG2'(1);
    localparam logic [3:0]            GUARD_INIT  = 4'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        GUARD,
        DRAIN
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [3:0]            guard_cnt;
    state_t                state;
    logic [7:0]            tx_data;
    logic                  tx_write;
    logic                  overflow;

    logic full;
    logic empty;
    logic push;
    logic drop;
    logic pop;

    // Full and empty come from the registered count, so a pop in the same
    // cycle never rescues a byte that arrives while full.
    assign full  = (count == DEPTH_COUNT);
    assign empty = (count == '0);
    assign push  = bus.in_valid_i && !full;
    assign drop  = bus.in_valid_i && full;
    assign pop   = (state == LOAD);

    assign bus.in_ready_o = !full;
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.count_o    = count;
    assign bus.tx_data_o  = tx_data;
    assign bus.tx_write_o = tx_write;
    assign bus.overflow_o = overflow;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= bus.in_data_i;
        end
    end

    // The guard window masks tx_busy_i while uart_tx has not yet raised busy
    // in response to our strobe; only after it do we trust busy to pace us.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            guard_cnt <= '0;
            tx_data   <= 8'h00;
            tx_write  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tx_write <= 1'b0;

            if (push) begin
                wptr <= wptr + PTR_STEP;
            end

            if (push && !pop) begin
                count <= count + COUNT_STEP;
            end else if (pop && !push) begin
                count <= count - COUNT_STEP;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clear_overflow_i) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!empty && !bus.tx_busy_i) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data  <= mem[rptr];
                    rptr     <= rptr + PTR_STEP;
                    tx_write <= 1'b1;
                    state    <= STROBE;
                end
                STROBE: begin
                    guard_cnt <= GUARD_INIT;
                    state     <= GUARD;
                end
                GUARD: begin
                    guard_cnt <= guard_cnt - 4'd1;
                    if (guard_cnt <= 4'd1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.tx_busy_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed phases with a random-latency
// transmitter model and an expected-byte queue as the reference.
module tb_uart_tx_fifo;
    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int GUARD       = 1;
    localparam int MIN_SPACING = 4 + GUARD;

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_tx_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         checkCount = 0;
    int         passCount  = 0;
    logic [7:0] expQ[$];
    int         countHist[$];
    int         expHist[4] = '{1, 2, 1, 0};
    int         lastCount = 0;
    int         strobeCount = 0;
    int         cycleCount = 0;
    int         lastStrobeCycle = 0;
    logic       prevWrite = 1'b0;
    logic       sawFull = 1'b0;
    int         busyRemaining = 0;
    logic       busyHold = 1'b0;
    logic       busyRandom = 1'b0;
    int         fixedBusyLen = 10;

    assign bus.tx_busy_i = busyHold || (busyRemaining != 0);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic clear);
        bus.in_valid_i       = valid;
        bus.in_data_i        = data;
        bus.clear_overflow_i = clear;
        @(negedge clock);
    endtask

    task automatic pushByte(input logic [7:0] data, input logic accept);
        if (accept) expQ.push_back(data);
        applyStimulus(1'b1, data, 1'b0);
    endtask

    task automatic waitDrain(input string tag);
        int stable = 0;
        int cycles = 0;
        while (stable < 4 && cycles < 3000) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            cycles++;
            if (expQ.size() == 0 && bus.tx_busy_i === 1'b0) stable++;
            else stable = 0;
        end
        checkOutput({tag, "_done"}, 32'(stable >= 4), 1);
    endtask

    // Transmitter model: busy rises the cycle after a strobe and lasts a
    // fixed or random number of cycles.
    always @(posedge clock) begin
        if (bus.tx_write_o === 1'b1) begin
            busyRemaining <= busyRandom ? int'($urandom_range(20, 0)) : fixedBusyLen;
        end else if (busyRemaining > 0) begin
            busyRemaining <= busyRemaining - 1;
        end
    end

    always @(negedge clock) begin
        cycleCount++;
        if (bus.full_o === 1'b1) sawFull = 1'b1;
        if (int'(bus.count_o) != lastCount) begin
            countHist.push_back(int'(bus.count_o));
            lastCount = int'(bus.count_o);
        end
        if (bus.tx_write_o === 1'b1) begin
            strobeCount++;
            checkOutput("strobe_one_cycle", 32'(prevWrite), 0);
            checkOutput("strobe_tx_idle", 32'(bus.tx_busy_i), 0);
            if (strobeCount > 1)
                checkOutput("strobe_spacing", 32'((cycleCount - lastStrobeCycle) >= MIN_SPACING), 1);
            lastStrobeCycle = cycleCount;
            checkOutput("strobe_expected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) checkOutput("strobe_data", 32'(bus.tx_data_o), 32'(expQ.pop_front()));
        end
        prevWrite = bus.tx_write_o;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid_i       = 1'b0;
        bus.in_data_i        = 8'h00;
        bus.clear_overflow_i = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] reset state");
        checkOutput("reset_count", 32'(bus.count_o), 0);
        checkOutput("reset_empty", 32'(bus.empty_o), 1);
        checkOutput("reset_full", 32'(bus.full_o), 0);
        checkOutput("reset_ready", 32'(bus.in_ready_o), 1);
        checkOutput("reset_write", 32'(bus.tx_write_o), 0);
        checkOutput("reset_data", 32'(bus.tx_data_o), 0);
        checkOutput("reset_overflow", 32'(bus.overflow_o), 0);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] two-byte reply");
        fixedBusyLen = 10;
        countHist.delete();
        pushByte(8'hA5, 1'b1);
        pushByte(8'h5A, 1'b1);
        waitDrain("two_byte_drain");
        checkOutput("two_byte_strobes", 32'(strobeCount), 2);
        checkOutput("count_hist_len", 32'(countHist.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < countHist.size())
                checkOutput($sformatf("count_hist_%0d", i), 32'(countHist[i]), 32'(expHist[i]));
        end

        $display("[TB] fill and overflow");
        busyHold = 1'b1;
        fixedBusyLen = 3;
        for (int i = 0; i < DEPTH; i++) pushByte(8'(i), 1'b1);
        checkOutput("fill_count", 32'(bus.count_o), DEPTH);
        checkOutput("fill_full", 32'(bus.full_o), 1);
        checkOutput("fill_ready", 32'(bus.in_ready_o), 0);
        checkOutput("fill_empty", 32'(bus.empty_o), 0);
        checkOutput("fill_overflow", 32'(bus.overflow_o), 0);
        pushByte(8'hFF, 1'b0);
        checkOutput("drop_overflow", 32'(bus.overflow_o), 1);
        checkOutput("drop_count", 32'(bus.count_o), DEPTH);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkOutput("overflow_set_wins", 32'(bus.overflow_o), 1);
        checkOutput("drop2_count", 32'(bus.count_o), DEPTH);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("overflow_cleared", 32'(bus.overflow_o), 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        busyHold = 1'b0;
        waitDrain("fill_drain");
        checkOutput("fill_strobes", 32'(strobeCount), 2 + DEPTH);
        checkOutput("fill_drain_empty", 32'(bus.empty_o), 1);

        $display("[TB] wrap stream");
        busyRandom = 1'b1;
        sawFull = 1'b0;
        for (int b = 0; b < 40; b++) begin
            int guardLoop;
            guardLoop = 0;
            while (expQ.size() >= 12 && guardLoop < 2000) begin
                applyStimulus(1'b0, 8'h00, 1'b0);
                guardLoop++;
            end
            pushByte(b[7:0], 1'b1);
            repeat ($urandom_range(3, 0)) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        waitDrain("wrap_drain");
        checkOutput("wrap_strobes", 32'(strobeCount), 2 + DEPTH + 40);
        checkOutput("wrap_never_full", 32'(sawFull), 0);
        checkOutput("wrap_overflow", 32'(bus.overflow_o), 0);
        checkOutput("wrap_count", 32'(bus.count_o), 0);

        $display("[TB] reset during guard");
        busyRandom = 1'b0;
        fixedBusyLen = 30;
        pushByte(8'h11, 1'b1);
        pushByte(8'h22, 1'b1);
        pushByte(8'h33, 1'b1);
        pushByte(8'h44, 1'b1);
        checkOutput("guard_count", 32'(bus.count_o), 3);
        checkOutput("guard_strobes", 32'(strobeCount), 2 + DEPTH + 41);
        reset = 1'b0;
        expQ.delete();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midreset_count", 32'(bus.count_o), 0);
        checkOutput("midreset_empty", 32'(bus.empty_o), 1);
        checkOutput("midreset_write", 32'(bus.tx_write_o), 0);
        checkOutput("midreset_data", 32'(bus.tx_data_o), 0);
        reset = 1'b1;
        pushByte(8'h3C, 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("busy_hold_strobes", 32'(strobeCount), 2 + DEPTH + 41);
        checkOutput("busy_hold_count", 32'(bus.count_o), 1);
        waitDrain("post_reset_drain");
        checkOutput("post_reset_strobes", 32'(strobeCount), 2 + DEPTH + 42);
        checkOutput("post_reset_count", 32'(bus.count_o), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the VRAM command engine's reply interface and the UART transmitter in the bringup designs. It absorbs multi-byte replies (e.g. two-byte READ results) as back-to-back bytes and paces them out to uart_tx one at a time using its busy flag. It also provides fill-level and sticky overflow status for LEDs and debug.

Parameters:
DEPTH_LOG2  4  log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries of 8 bits
GUARD_CYCLES  1  cycles after the write strobe during which tx_busy_i is ignored, covering the transmitter's busy latency; legal range 1..15

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
in_data_i  input  8  byte to enqueue
in_valid_i  input  1  enqueue request, qualified by in_ready_o
in_ready_o  output  1  high when the FIFO can accept a byte this cycle
tx_data_o  output  8  byte presented to uart_tx data_i
tx_write_o  output  1  one-cycle write strobe to uart_tx write_i
tx_busy_i  input  1  uart_tx busy_o
count_o  output  DEPTH_LOG2+1  current number of stored entries
empty_o  output  1  count_o == 0
full_o  output  1  count_o == depth
overflow_o  output  1  sticky: a byte arrived while full
clear_overflow_i  input  1  clears overflow_o

Behaviour:
- Reset is synchronous, active-low; clock is clock. While reset==0:
  - read and write pointers and count go to 0.
  - state goes to IDLE, tx_write_o=0, tx_data_o=8'h00, overflow_o=0.
  - in_ready_o=1, empty_o=1, full_o=0.
  - Stored memory contents are don't-care.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth. count is a separate register of DEPTH_LOG2+1 bits.
- Push: when in_valid_i && in_ready_o, the byte is written at wptr and wptr increments. It is visible to the pop side on the next cycle.
- in_ready_o = !full_o, combinational from registered count. Upstream may assert in_valid_i only when ready; the block still guards against a push while full.
- Push while full: the byte is dropped, pointers and count are unchanged, and overflow_o sets on the next edge.
  - This holds even if a pop occurs in the same cycle, because full is evaluated from the registered count.
- overflow_o clears when clear_overflow_i=1. If a drop and a clear occur in the same cycle, set wins.
- Pop state machine:
  - IDLE:
    - If !empty and !tx_busy_i, go to LOAD.
    - If tx_busy_i is high (e.g. after reset mid-frame), stay in IDLE.
  - LOAD:
    - tx_data_o <= mem[rptr], rptr increments, count decrements.
    - Go to STROBE.
  - STROBE:
    - tx_write_o=1 for exactly this cycle.
    - Load the guard counter with GUARD_CYCLES; go to GUARD.
  - GUARD:
    - Ignore tx_busy_i and decrement the counter.
    - When the counter reaches 1, go to DRAIN.
  - DRAIN:
    - Wait for tx_busy_i==0, then go to IDLE.
  - Any unencoded state returns to IDLE.
- tx_data_o is held stable from LOAD until the next LOAD.
- Minimum spacing between strobes is 4+GUARD_CYCLES cycles when the transmitter finishes instantly. Real spacing is set by the busy duration.
- Simultaneous push and pop (LOAD cycle) when neither full nor empty: count is unchanged, and both pointers advance.
- Fill boundaries:
  - count reaches depth exactly after depth pushes with no pops.
  - empty_o and full_o are never both high.
- Reset mid-operation:
  - A byte already strobed into uart_tx is not recalled.
  - Queued bytes are discarded.
  - After reset, the FIFO waits in IDLE for tx_busy_i low before sending newly pushed data.
- Pop order is strictly FIFO. No byte is duplicated or skipped across pointer wrap.

Test Plan:
- Reset with tx_busy_i=0 → count_o=0, empty_o=1, in_ready_o=1, tx_write_o=0, overflow_o=0.
- Push 8'hA5 then 8'h5A on consecutive cycles; the busy model holds busy for 10 cycles after each strobe → two strobes carrying A5 then 5A, second strobe not before busy falls; count_o goes 1,2,1,0.
- DEPTH_LOG2=4, tx_busy_i held 1:
  - push 16 bytes → full_o=1, in_ready_o=0;
  - 17th push of 8'hFF → dropped, overflow_o=1;
  - release busy → bytes 0..15 emerge in order, no FF.
- Push/pop wrap: stream 40 bytes 0x00..0x27 with random busy durations 0-20 cycles → output sequence identical, never full.
- Overflow and clear_overflow_i asserted in the same cycle → overflow_o=1; a clear on a later cycle with no drop → 0.
- Reset asserted in GUARD with 3 bytes queued → next cycle state IDLE, count_o=0. With tx_busy_i still 1, no strobe until busy falls, then the next pushed byte 8'h3C is sent.
